// File: rtl/am_pkg.sv
// rtl/am_pkg.sv - shared widths and FSM state type for the approximate-multiplier error meter
package am_pkg;
   localparam int OPND_W = 8;
   localparam int PROD_W = 16;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_DRAIN,
      ST_DONE
   } am_state_t;
endpackage

// File: rtl/am_abs_diff.sv
// rtl/am_abs_diff.sv - two-stage pipe: exact product, then |z - x*y| and mismatch flag
module am_abs_diff
   import am_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   input  logic [OPND_W-1:0] x,
   input  logic [OPND_W-1:0] y,
   input  logic [PROD_W-1:0] z,
   output logic              s1_valid,
   output logic              diff_valid,
   output logic [PROD_W-1:0] diff,
   output logic              mismatch
);
   logic [PROD_W-1:0]   prod_r;
   logic [PROD_W-1:0]   z_r;
   logic signed [PROD_W:0] delta;
   logic [PROD_W-1:0]   mag;

   // One extra bit keeps the difference exact; the magnitude always fits 16 bits.
   always_comb begin
      delta = signed'({1'b0, z_r}) - signed'({1'b0, prod_r});
      mag   = PROD_W'(delta[PROD_W] ? -delta : delta);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid   <= 1'b0;
         diff_valid <= 1'b0;
      end else begin
         s1_valid   <= in_valid;
         diff_valid <= s1_valid;
      end
      prod_r   <= PROD_W'(x) * PROD_W'(y);
      z_r      <= z;
      diff     <= mag;
      mismatch <= (z_r != prod_r);
   end
endmodule

// File: rtl/am_err_meter.sv
// rtl/am_err_meter.sv - per-frame error statistics for an approximate 8x8 multiplier
module am_err_meter
   import am_pkg::*;
#(
   parameter int CNT_W = 17,
   parameter int SUM_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [CNT_W-1:0]  len,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [OPND_W-1:0] x,
   input  logic [OPND_W-1:0] y,
   input  logic [PROD_W-1:0] z,
   output logic [CNT_W-1:0]  err_cnt,
   output logic [SUM_W-1:0]  abs_sum,
   output logic [PROD_W-1:0] max_err,
   output logic              done
);
   localparam int EXT_W = ((SUM_W > PROD_W) ? SUM_W : PROD_W) + 1;

   am_state_t         state;
   logic [CNT_W-1:0]  len_r;
   logic [CNT_W-1:0]  cnt;
   logic              accept;
   logic              s1_valid;
   logic              d_valid;
   logic              d_mis;
   logic [PROD_W-1:0] d_mag;
   logic [EXT_W-1:0]  sum_ext;
   logic              sum_sat;

   assign accept = in_valid && in_ready;

   am_abs_diff u_abs_diff (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (accept),
      .x          (x),
      .y          (y),
      .z          (z),
      .s1_valid   (s1_valid),
      .diff_valid (d_valid),
      .diff       (d_mag),
      .mismatch   (d_mis)
   );

   // Widened add exposes any carry past SUM_W so the sum clamps instead of wrapping.
   always_comb begin
      sum_ext = EXT_W'(abs_sum) + EXT_W'(d_mag);
      sum_sat = |sum_ext[EXT_W-1:SUM_W];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= ST_IDLE;
         in_ready <= 1'b0;
         done     <= 1'b0;
         cnt      <= '0;
         len_r    <= '0;
         err_cnt  <= '0;
         abs_sum  <= '0;
         max_err  <= '0;
      end else begin
         if (d_valid) begin
            err_cnt <= err_cnt + CNT_W'(d_mis);
            abs_sum <= sum_sat ? '1 : sum_ext[SUM_W-1:0];
            if (d_mag > max_err) max_err <= d_mag;
         end
         case (state)
            ST_IDLE, ST_DONE: begin
               if (start) begin
                  cnt     <= '0;
                  len_r   <= len;
                  err_cnt <= '0;
                  abs_sum <= '0;
                  max_err <= '0;
                  if (len != '0) begin
                     state    <= ST_RUN;
                     in_ready <= 1'b1;
                     done     <= 1'b0;
                  end else begin
                     state <= ST_DONE;
                     done  <= 1'b1;
                  end
               end
            end
            ST_RUN: begin
               if (accept) begin
                  cnt <= cnt + CNT_W'(1);
                  if (cnt + CNT_W'(1) == len_r) begin
                     state    <= ST_DRAIN;
                     in_ready <= 1'b0;
                  end
               end
            end
            // Last sample sits in stage 2 once stage 1 empties; it lands with this edge.
            ST_DRAIN: begin
               if (!s1_valid) begin
                  state <= ST_DONE;
                  done  <= 1'b1;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_am_err_meter.sv
// tb/tb_am_err_meter.sv - randomized and directed checks of am_err_meter against a timestamp model
module tb_am_err_meter;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [16:0] len = '0;
   logic        in_valid = 1'b0;
   logic [7:0]  x = '0;
   logic [7:0]  y = '0;
   logic [15:0] z = '0;

   logic        in_ready, done, in_ready_b, done_b;
   logic [16:0] err_cnt, err_cnt_b;
   logic [31:0] abs_sum;
   logic [7:0]  abs_sum_b;
   logic [15:0] max_err, max_err_b;

   am_err_meter u_dut (
      .clk(clk), .rst(rst), .start(start), .len(len), .in_valid(in_valid),
      .in_ready(in_ready), .x(x), .y(y), .z(z), .err_cnt(err_cnt),
      .abs_sum(abs_sum), .max_err(max_err), .done(done)
   );

   am_err_meter #(.SUM_W(8)) u_dut8 (
      .clk(clk), .rst(rst), .start(start), .len(len), .in_valid(in_valid),
      .in_ready(in_ready_b), .x(x), .y(y), .z(z), .err_cnt(err_cnt_b),
      .abs_sum(abs_sum_b), .max_err(max_err_b), .done(done_b)
   );

   always #5 clk = ~clk;

   typedef struct {
      int t;
      int d;
   } samp_t;

   samp_t q[$];
   int    cyc = 0;
   int    m_len = 0;
   int    m_cnt = 0;
   int    m_done_at = -1;
   bit    m_started = 1'b0;
   int    checks = 0;
   int    failures = 0;
   int    sx[$], sy[$], sz[$];

   function automatic void chk(string name, longint act, longint exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endfunction

   function automatic int absdiff(int a, int b, int c);
      int d;
      d = c - a * b;
      return (d < 0) ? -d : d;
   endfunction

   function automatic bit m_ready();
      return m_started && (m_done_at < 0);
   endfunction

   function automatic bit m_busy();
      return m_started && (m_done_at < 0 || cyc < m_done_at);
   endfunction

   function automatic bit m_done_now();
      return (m_done_at >= 0) && (cyc >= m_done_at);
   endfunction

   // Model: every accepted sample is stamped with its cycle and counts from stamp+3.
   initial forever begin
      @(posedge clk);
      if (rst) begin
         q.delete();
         m_started = 1'b0;
         m_cnt = 0;
         m_len = 0;
         m_done_at = -1;
      end else if (start && !m_busy()) begin
         q.delete();
         m_cnt = 0;
         m_len = int'(len);
         if (len != 0) begin
            m_started = 1'b1;
            m_done_at = -1;
         end else begin
            m_started = 1'b0;
            m_done_at = cyc + 1;
         end
      end else if (m_ready() && in_valid) begin
         q.push_back('{cyc, absdiff(int'(x), int'(y), int'(z))});
         m_cnt++;
         if (m_cnt == m_len) m_done_at = cyc + 3;
      end
      cyc++;
   end

   initial forever begin
      longint e_cnt, e_sum, e_max;
      @(negedge clk);
      if (cyc > 0) begin
         e_cnt = 0;
         e_sum = 0;
         e_max = 0;
         foreach (q[i]) begin
            if (q[i].t <= cyc - 3) begin
               if (q[i].d != 0) e_cnt++;
               e_sum += q[i].d;
               if (q[i].d > e_max) e_max = q[i].d;
            end
         end
         chk("in_ready", in_ready, m_ready());
         chk("done", done, m_done_now());
         chk("err_cnt", err_cnt, e_cnt);
         chk("abs_sum", abs_sum, e_sum);
         chk("max_err", max_err, e_max);
         chk("in_ready_s8", in_ready_b, m_ready());
         chk("done_s8", done_b, m_done_now());
         chk("err_cnt_s8", err_cnt_b, e_cnt);
         chk("abs_sum_s8", abs_sum_b, (e_sum > 255) ? 255 : e_sum);
         chk("max_err_s8", max_err_b, e_max);
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic add(input int a, input int b, input int c);
      sx.push_back(a);
      sy.push_back(b);
      sz.push_back(c);
   endtask

   task automatic feed(input int n, input int gap, input bit noise);
      int idx;
      int guard;
      bit acc;
      idx = 0;
      guard = 0;
      while (idx < n && idx < sx.size() && guard < 2000) begin
         in_valid = ($urandom_range(0, 99) >= gap);
         if (in_valid) begin
            x = 8'(sx[idx]);
            y = 8'(sy[idx]);
            z = 16'(sz[idx]);
         end else begin
            x = 8'($urandom);
            y = 8'($urandom);
            z = 16'($urandom);
         end
         if (noise) begin
            start = ($urandom_range(0, 7) == 0);
            len = 17'($urandom_range(0, 9));
         end
         acc = in_valid && m_ready();
         step();
         if (acc) idx++;
         guard++;
      end
      in_valid = 1'b0;
      start = 1'b0;
   endtask

   task automatic run_frame(input int n, input int gap, input bit noise);
      int guard;
      start = 1'b1;
      len = 17'(n);
      in_valid = 1'b0;
      step();
      start = 1'b0;
      feed(n, gap, noise);
      guard = 0;
      while (!m_done_now() && guard < 40) begin
         step();
         guard++;
      end
      chk("frame_completes", m_done_now(), 1);
      sx.delete();
      sy.delete();
      sz.delete();
   endtask

   initial begin
      int n, a, b, p;
      repeat (3) step();
      chk("rst_in_ready", in_ready, 0);
      chk("rst_done", done, 0);
      chk("rst_err_cnt", err_cnt, 0);
      chk("rst_abs_sum", abs_sum, 0);
      chk("rst_max_err", max_err, 0);
      rst = 1'b0;
      step();

      add(3, 3, 5);
      run_frame(1, 0, 0);
      chk("single_done", done, 1);
      chk("single_err_cnt", err_cnt, 1);
      chk("single_abs_sum", abs_sum, 4);
      chk("single_max_err", max_err, 4);

      add(255, 255, 65025); add(16, 16, 256); add(0, 7, 0);
      run_frame(3, 0, 0);
      chk("exact_err_cnt", err_cnt, 0);
      chk("exact_abs_sum", abs_sum, 0);
      chk("exact_max_err", max_err, 0);

      add(10, 10, 90); add(200, 200, 40100);
      run_frame(2, 60, 0);
      chk("gaps_err_cnt", err_cnt, 2);
      chk("gaps_abs_sum", abs_sum, 110);
      chk("gaps_max_err", max_err, 100);

      start = 1'b1;
      len = '0;
      step();
      start = 1'b0;
      chk("len0_done", done, 1);
      chk("len0_in_ready", in_ready, 0);
      chk("len0_err_cnt", err_cnt, 0);
      chk("len0_abs_sum", abs_sum, 0);
      step();

      repeat (4) add(10, 10, 200);
      run_frame(4, 20, 0);
      chk("sat_abs_sum_s8", abs_sum_b, 255);
      chk("sat_err_cnt_s8", err_cnt_b, 4);
      chk("sat_abs_sum_32", abs_sum, 400);

      add(2, 3, 7); add(4, 5, 9);
      start = 1'b1;
      len = 17'd5;
      step();
      start = 1'b0;
      feed(2, 0, 0);
      sx.delete(); sy.delete(); sz.delete();
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("midrst_in_ready", in_ready, 0);
      chk("midrst_done", done, 0);
      chk("midrst_err_cnt", err_cnt, 0);
      chk("midrst_abs_sum", abs_sum, 0);
      chk("midrst_max_err", max_err, 0);
      repeat (4) step();
      chk("midrst_no_accum", abs_sum, 0);
      add(1, 1, 1);
      run_frame(1, 0, 0);
      chk("after_rst_err_cnt", err_cnt, 0);
      chk("after_rst_done", done, 1);

      for (int f = 0; f < 14; f++) begin
         n = $urandom_range(1, 12);
         for (int i = 0; i < n; i++) begin
            a = $urandom_range(0, 255);
            b = $urandom_range(0, 255);
            p = a * b;
            case ($urandom_range(0, 3))
               0, 1: add(a, b, p);
               2:    add(a, b, (p + $urandom_range(1, 300)) % 65536);
               default: add(a, b, $urandom_range(0, 65535));
            endcase
         end
         run_frame(n, $urandom_range(0, 60), 1'b1);
         repeat ($urandom_range(0, 3)) step();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
